// File: rtl/epl_pkg.sv
// Shared types and constants for the EPL serial bus host.
package epl_pkg;

  localparam int EPL_DATA_W = 32;
  localparam int EPL_DIV_W  = 8;
  localparam int EPL_TMO_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_DONE     = 3'd5
  } epl_host_state_t;

  // True in the states whose duration is timed by the SCLK divider.
  function automatic logic epl_div_active(input epl_host_state_t st);
    logic act;
    case (st)
      ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH: act = 1'b1;
      default:                            act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/epl_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module epl_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/epl_serial_host.sv
// EPL serial bus master: one full-duplex MSB-first frame per start, then an SLE latch pulse.
module epl_serial_host
  import epl_pkg::*;
#(
  parameter int DATA_W      = EPL_DATA_W,
  parameter int CLK_DIV     = 4,
  parameter int RDY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rd_data,
  output logic              epl_sclk,
  output logic              epl_sdo,
  input  logic              epl_sdi,
  output logic              epl_sle,
  input  logic              epl_srdy
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [EPL_DIV_W-1:0] DIV_LAST = EPL_DIV_W'(CLK_DIV - 1);
  localparam logic [EPL_TMO_W-1:0] TMO_LAST = EPL_TMO_W'(RDY_TIMEOUT - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_W - 1);

  logic sdi_s;
  logic srdy_s;

  epl_sync2 u_sync_sdi (
    .clk   (clk),
    .reset (reset),
    .d     (epl_sdi),
    .q     (sdi_s)
  );

  epl_sync2 u_sync_srdy (
    .clk   (clk),
    .reset (reset),
    .d     (epl_srdy),
    .q     (srdy_s)
  );

  epl_host_state_t   state_q, state_d;
  logic [EPL_DIV_W-1:0] div_q, div_d;
  logic [EPL_TMO_W-1:0] tmo_q, tmo_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              sle_q, sle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              tc_s;

  assign tc_s = (div_q == DIV_LAST);

  // Next-state, datapath and output decode; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    tmo_d     = tmo_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = wr_data;
          bit_d   = '0;
          tmo_d   = '0;
          state_d = ST_WAIT_RDY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (srdy_s) begin
          state_d = ST_SHIFT_LO;
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + EPL_TMO_W'(1);
        end
      end
      ST_SHIFT_LO: begin
        if (tc_s) begin
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (tc_s) begin
          shift_d = {shift_q[DATA_W-2:0], sdi_s};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end else begin
            state_d = ST_SHIFT_LO;
          end
        end else begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_LATCH: begin
        if (tc_s) begin
          rd_d    = shift_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_LATCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Divider restarts on every state change and rests at zero outside timed states.
    if ((state_d != state_q) || !epl_div_active(state_q)) begin
      div_d = '0;
    end else begin
      div_d = div_q + EPL_DIV_W'(1);
    end

    sclk_d = (state_d == ST_SHIFT_HI);
    sle_d  = (state_d == ST_LATCH);
    busy_d = (state_d != ST_IDLE);
    // Shift register only moves at the end of SHIFT_HI, so the MSB is stable across the rising edge.
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
      sdo_d = shift_d[DATA_W-1];
    end else begin
      sdo_d = 1'b0;
    end
  end

  // State and registered outputs, all forced to their idle values by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      tmo_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rd_q      <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      sle_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      sle_q     <= sle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign rd_data  = rd_q;
  assign epl_sclk = sclk_q;
  assign epl_sdo  = sdo_q;
  assign epl_sle  = sle_q;

endmodule

// File: tb/tb_epl_serial_host.sv
// Self-checking bench: loopback slave on instance A (defaults), stuck-level slave on instance B (CLK_DIV=3, RDY_TIMEOUT=16).
module tb_epl_serial_host;

  localparam logic [31:0] SLAVE_WORD = 32'hA5C30F12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rd_a_q[$];
  logic [31:0] exp_lat_a_q[$];
  logic [31:0] exp_rd_b_q[$];

  logic        start_a, busy_a, done_a, tmo_a, sclk_a, sdo_a, sdi_a, sle_a, srdy_a;
  logic [31:0] wr_a, rd_a;
  logic        start_b, busy_b, done_b, tmo_b, sclk_b, sdo_b, sdi_b, sle_b, srdy_b;
  logic [31:0] wr_b, rd_b;

  epl_serial_host dut_a (
    .clk(clk), .reset(reset), .start(start_a), .wr_data(wr_a), .busy(busy_a),
    .done(done_a), .timeout(tmo_a), .rd_data(rd_a), .epl_sclk(sclk_a),
    .epl_sdo(sdo_a), .epl_sdi(sdi_a), .epl_sle(sle_a), .epl_srdy(srdy_a)
  );

  epl_serial_host #(.DATA_W(32), .CLK_DIV(3), .RDY_TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .wr_data(wr_b), .busy(busy_b),
    .done(done_b), .timeout(tmo_b), .rd_data(rd_b), .epl_sclk(sclk_b),
    .epl_sdo(sdo_b), .epl_sdi(sdi_b), .epl_sle(sle_b), .epl_srdy(srdy_b)
  );

  // Loopback slave for A: shifts sdo in on SCLK rise, shifts its word out after SCLK fall.
  logic [31:0] sl_out, sl_in, sl_latched;
  logic        asclk_p, asle_p;
  int          a_rise = 0;
  int          a_sle  = 0;
  assign sdi_a = sl_out[31];
  always @(posedge clk) begin
    if (reset) begin
      sl_out  <= SLAVE_WORD;
      sl_in   <= 32'h0;
      asclk_p <= 1'b0;
      asle_p  <= 1'b0;
    end else begin
      asclk_p <= sclk_a;
      asle_p  <= sle_a;
      if (sclk_a && !asclk_p) begin
        sl_in  <= {sl_in[30:0], sdo_a};
        a_rise <= a_rise + 1;
      end
      if (!sclk_a && asclk_p) sl_out <= {sl_out[30:0], 1'b0};
      if (sle_a && !asle_p) begin
        sl_latched <= sl_in;
        a_sle      <= a_sle + 1;
      end
      if (!sle_a && asle_p) sl_out <= SLAVE_WORD;
    end
  end

  // Monitor for B: phase lengths, sdo stability while SCLK rises/high, captured frame.
  logic        bsclk_p, bsdo_p, bsle_p, b_lo_valid;
  logic [31:0] b_in;
  int          b_hi_len = 0;
  int          b_lo_len = 0;
  int          b_rise = 0;
  int          b_sle = 0;
  int          b_phase_err = 0;
  int          b_sdo_err = 0;
  always @(posedge clk) begin
    if (reset) begin
      bsclk_p    <= 1'b0;
      bsdo_p     <= 1'b0;
      bsle_p     <= 1'b0;
      b_lo_valid <= 1'b0;
      b_in       <= 32'h0;
    end else begin
      bsclk_p <= sclk_b;
      bsdo_p  <= sdo_b;
      bsle_p  <= sle_b;
      if (sclk_b && !bsclk_p) begin
        b_rise   <= b_rise + 1;
        b_in     <= {b_in[30:0], sdo_b};
        b_hi_len <= 1;
        if (sdo_b !== bsdo_p) b_sdo_err <= b_sdo_err + 1;
        if (b_lo_valid && (b_lo_len != 3)) b_phase_err <= b_phase_err + 1;
      end else if (sclk_b) begin
        b_hi_len <= b_hi_len + 1;
        if (sdo_b !== bsdo_p) b_sdo_err <= b_sdo_err + 1;
      end
      if (!sclk_b && bsclk_p) begin
        if (b_hi_len != 3) b_phase_err <= b_phase_err + 1;
        b_lo_len   <= 1;
        b_lo_valid <= 1'b1;
      end else if (!sclk_b) begin
        b_lo_len <= b_lo_len + 1;
      end
      if (sle_b && !bsle_p) begin
        b_sle      <= b_sle + 1;
        b_lo_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sclk_a, sdo_a, sle_a, busy_a, done_a, tmo_a} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b expected 000000", {sclk_a, sdo_a, sle_a, busy_a, done_a, tmo_a});
    end
    checks++;
    if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_rd_a: got %h expected 00000000", rd_a); end
    checks++;
    if ({sclk_b, sdo_b, sle_b, busy_b, done_b, tmo_b} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_b: got %b expected 000000", {sclk_b, sdo_b, sle_b, busy_b, done_b, tmo_b});
    end
    checks++;
    if (rd_b !== 32'h0) begin errors++; $display("FAIL reset_rd_b: got %h expected 00000000", rd_b); end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic(input logic [31:0] wd, input string tag);
    int s, lat, r0, e0, busy_bad;
    logic [31:0] ev;
    wr_a = wd;
    exp_rd_a_q.push_back(SLAVE_WORD);
    exp_lat_a_q.push_back(wd);
    start_a = 1'b1;
    s = cyc; r0 = a_rise; e0 = a_sle; lat = -1; busy_bad = 0;
    tick();
    start_a = 1'b0;
    while (lat < 0 && (cyc - s) <= 400) begin
      if (busy_a !== 1'b1) busy_bad++;
      if (done_a === 1'b1) lat = cyc - s;
      else tick();
    end
    checks++;
    if (lat != 262) begin errors++; $display("FAIL %s_latency: got %0d expected 262", tag, lat); end
    ev = exp_rd_a_q.pop_front();
    checks++;
    if (rd_a !== ev) begin errors++; $display("FAIL %s_rd_data: got %h expected %h", tag, rd_a, ev); end
    ev = exp_lat_a_q.pop_front();
    checks++;
    if (sl_latched !== ev) begin errors++; $display("FAIL %s_slave_latch: got %h expected %h", tag, sl_latched, ev); end
    checks++;
    if ((a_rise - r0) != 32 || (a_sle - e0) != 1) begin
      errors++; $display("FAIL %s_edges: got rises=%0d sle=%0d expected 32 and 1", tag, a_rise - r0, a_sle - e0);
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL %s_busy_window: got %0d low cycles expected 0", tag, busy_bad); end
    tick();
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL %s_after_done: got busy,done=%b expected 00", tag, {busy_a, done_a}); end
  endtask

  task automatic test_srdy_wait();
    int s, lat, r0, tmo_seen, busy_bad;
    logic [31:0] ev;
    srdy_a = 1'b0;
    repeat (4) tick();
    wr_a = 32'h0F0F55AA;
    exp_rd_a_q.push_back(SLAVE_WORD);
    exp_lat_a_q.push_back(32'h0F0F55AA);
    start_a = 1'b1;
    s = cyc; r0 = a_rise; lat = -1; tmo_seen = 0; busy_bad = 0;
    tick();
    start_a = 1'b0;
    while ((cyc - s) < 500) begin
      if (busy_a !== 1'b1) busy_bad++;
      tick();
    end
    checks++;
    if (a_rise != r0 || busy_bad != 0) begin
      errors++; $display("FAIL wait_idle_bus: got rises=%0d busy_low=%0d expected 0 and 0", a_rise - r0, busy_bad);
    end
    srdy_a = 1'b1;
    while (lat < 0 && (cyc - s) <= 900) begin
      if (tmo_a === 1'b1) tmo_seen++;
      if (done_a === 1'b1) lat = cyc - s;
      else tick();
    end
    checks++;
    if (lat < 760 || lat > 764) begin errors++; $display("FAIL wait_latency: got %0d expected 760..764", lat); end
    checks++;
    if (tmo_seen != 0) begin errors++; $display("FAIL wait_no_timeout: got %0d pulses expected 0", tmo_seen); end
    ev = exp_rd_a_q.pop_front();
    checks++;
    if (rd_a !== ev) begin errors++; $display("FAIL wait_rd_data: got %h expected %h", rd_a, ev); end
    ev = exp_lat_a_q.pop_front();
    checks++;
    if (sl_latched !== ev) begin errors++; $display("FAIL wait_slave_latch: got %h expected %h", sl_latched, ev); end
    tick();
  endtask

  task automatic test_back_to_back();
    int s, n, r_prev, e_prev, quiet_bad;
    logic [31:0] ev;
    wr_a = 32'h3C3C9669;
    for (int k = 0; k < 4; k++) begin
      exp_rd_a_q.push_back(SLAVE_WORD);
      exp_lat_a_q.push_back(32'h3C3C9669);
    end
    start_a = 1'b1;
    s = cyc; n = 0; r_prev = a_rise; e_prev = a_sle; quiet_bad = 0;
    while (n < 4 && (cyc - s) < 1400) begin
      if ((cyc - s) == 1000) start_a = 1'b0;
      if (done_a === 1'b1) begin
        checks++;
        if ((cyc - s) != 262 + 263 * n) begin
          errors++; $display("FAIL b2b_done_time%0d: got %0d expected %0d", n, cyc - s, 262 + 263 * n);
        end
        ev = exp_rd_a_q.pop_front();
        checks++;
        if (rd_a !== ev) begin errors++; $display("FAIL b2b_rd%0d: got %h expected %h", n, rd_a, ev); end
        ev = exp_lat_a_q.pop_front();
        checks++;
        if (sl_latched !== ev) begin errors++; $display("FAIL b2b_latch%0d: got %h expected %h", n, sl_latched, ev); end
        checks++;
        if ((a_rise - r_prev) != 32 || (a_sle - e_prev) != 1) begin
          errors++; $display("FAIL b2b_edges%0d: got rises=%0d sle=%0d expected 32 and 1", n, a_rise - r_prev, a_sle - e_prev);
        end
        r_prev = a_rise; e_prev = a_sle; n++;
      end
      tick();
    end
    start_a = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL b2b_frames: got %0d expected 4", n); end
    repeat (300) begin
      if (done_a === 1'b1 || busy_a === 1'b1) quiet_bad++;
      tick();
    end
    checks++;
    if (quiet_bad != 0) begin errors++; $display("FAIL b2b_no_extra: got %0d busy/done cycles expected 0", quiet_bad); end
  endtask

  task automatic test_clkdiv3();
    logic [31:0] wds[2];
    logic        sdis[2];
    logic [31:0] ev;
    int s, lat, r0, e0, p0, d0;
    wds[0] = 32'hFFFFFFFF; sdis[0] = 1'b0;
    wds[1] = 32'h00000000; sdis[1] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      sdi_b = sdis[f];
      wr_b  = wds[f];
      repeat (3) tick();
      exp_rd_b_q.push_back(sdis[f] ? 32'hFFFFFFFF : 32'h00000000);
      start_b = 1'b1;
      s = cyc; lat = -1; r0 = b_rise; e0 = b_sle; p0 = b_phase_err; d0 = b_sdo_err;
      tick();
      start_b = 1'b0;
      while (lat < 0 && (cyc - s) <= 300) begin
        if (done_b === 1'b1) lat = cyc - s;
        else tick();
      end
      checks++;
      if (lat != 197) begin errors++; $display("FAIL div3_latency%0d: got %0d expected 197", f, lat); end
      ev = exp_rd_b_q.pop_front();
      checks++;
      if (rd_b !== ev) begin errors++; $display("FAIL div3_rd%0d: got %h expected %h", f, rd_b, ev); end
      checks++;
      if (b_in !== wds[f]) begin errors++; $display("FAIL div3_sdo_bits%0d: got %h expected %h", f, b_in, wds[f]); end
      checks++;
      if ((b_rise - r0) != 32 || (b_sle - e0) != 1) begin
        errors++; $display("FAIL div3_edges%0d: got rises=%0d sle=%0d expected 32 and 1", f, b_rise - r0, b_sle - e0);
      end
      checks++;
      if ((b_phase_err - p0) != 0 || (b_sdo_err - d0) != 0) begin
        errors++; $display("FAIL div3_phase%0d: got phase_err=%0d sdo_err=%0d expected 0 and 0", f, b_phase_err - p0, b_sdo_err - d0);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int s, lat, r0, e0, done_seen;
    srdy_b = 1'b0;
    repeat (4) tick();
    wr_b = 32'h13579BDF;
    start_b = 1'b1;
    s = cyc; lat = -1; r0 = b_rise; e0 = b_sle; done_seen = 0;
    tick();
    start_b = 1'b0;
    while (lat < 0 && (cyc - s) <= 40) begin
      if (done_b === 1'b1) done_seen++;
      if (tmo_b === 1'b1) lat = cyc - s;
      else tick();
    end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL tmo_latency: got %0d expected 17", lat); end
    checks++;
    if (busy_b !== 1'b0 || done_seen != 0) begin
      errors++; $display("FAIL tmo_flags: got busy=%b done_seen=%0d expected 0 and 0", busy_b, done_seen);
    end
    checks++;
    if (rd_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL tmo_rd_held: got %h expected ffffffff", rd_b); end
    checks++;
    if (b_rise != r0 || b_sle != e0) begin
      errors++; $display("FAIL tmo_bus_quiet: got rises=%0d sle=%0d expected 0 and 0", b_rise - r0, b_sle - e0);
    end
    tick();
    checks++;
    if (tmo_b !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", tmo_b); end
    srdy_b = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_mid_frame_reset();
    int s, r0, e0, quiet_bad;
    wr_a = 32'h77AA1100;
    start_a = 1'b1;
    s = cyc; r0 = a_rise; e0 = a_sle;
    tick();
    start_a = 1'b0;
    while ((a_rise - r0) < 10 && (cyc - s) <= 200) tick();
    checks++;
    if ((a_rise - r0) != 10) begin errors++; $display("FAIL rst_reach_edge10: got %0d expected 10", a_rise - r0); end
    reset = 1'b1;
    tick();
    checks++;
    if ({sclk_a, sle_a, busy_a, done_a} !== 4'b0000) begin
      errors++; $display("FAIL rst_ctrl: got sclk,sle,busy,done=%b expected 0000", {sclk_a, sle_a, busy_a, done_a});
    end
    checks++;
    if (rd_a !== 32'h0) begin errors++; $display("FAIL rst_rd_clear: got %h expected 00000000", rd_a); end
    reset = 1'b0;
    quiet_bad = 0;
    repeat (300) begin
      if (done_a === 1'b1 || busy_a === 1'b1) quiet_bad++;
      tick();
    end
    checks++;
    if ((a_sle - e0) != 0 || quiet_bad != 0) begin
      errors++; $display("FAIL rst_no_sle: got sle=%0d busy/done=%0d expected 0 and 0", a_sle - e0, quiet_bad);
    end
    test_basic(32'hCAFEF00D, "post_rst");
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; wr_a = 32'h0; srdy_a = 1'b1;
    start_b = 1'b0; wr_b = 32'h0; srdy_b = 1'b1; sdi_b = 1'b0;
    test_reset();
    test_basic(32'h12345678, "basic");
    test_srdy_wait();
    test_back_to_back();
    test_clkdiv3();
    test_timeout();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms expected finish");
    $fatal(1);
  end

endmodule
